exe_divider: RTL and testbench

EXE_DIVIDER -- requirements
Module: exe_divider

---
 rtl/exe_divider.sv | 139 +++++++++++++
 tb/tb_exe_divider.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_divider.sv
// exe_divider
//   Iterative 32-bit integer divider for the execute stage (DIV / DIVU).
//   A restoring radix-2 engine retires one quotient bit per cycle. The result
//   is presented 33 cycles after the issuing cycle. Signed operands are
//   reduced to magnitudes on capture and sign-corrected on completion.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        issue a divide (honoured only in IDLE)
//   signed_div   1 = signed DIV, 0 = unsigned DIVU (sampled with start)
//   opa, opb     dividend / divisor (sampled with start)
//   cancel       execute-stage flush, aborts any operation
//   hold         downstream stall, keeps a finished result presented
//   stall_req    stall request to the pipeline
//   result_valid quotient/remainder valid this cycle
//   quotient     LO value
//   remainder    HI value
module exe_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        cancel,
    input  logic        hold,
    output logic        stall_req,
    output logic        result_valid,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  count;
    logic [63:0] partRem;     // {running remainder, dividend bits / quotient bits}
    logic [31:0] divisor;
    logic        qNeg;
    logic        rNeg;
    logic        divZero;
    logic        resultValid;
    logic [31:0] quotientReg;
    logic [31:0] remainderReg;

    logic        aNeg;
    logic        bNeg;
    logic [63:0] shifted;
    logic [32:0] trial;
    logic [63:0] stepRem;

    // Two's-complement negate when neg is set; used both for taking
    // magnitudes at capture and for restoring signs at completion.
    function automatic logic [31:0] applySign(input logic signed [31:0] v, input logic neg);
        logic signed [31:0] r;
        r = neg ? -v : v;
        return r;
    endfunction

    assign aNeg = signed_div & opa[31];
    assign bNeg = signed_div & opb[31];

    // One restoring step: shift left, trial-subtract the divisor from the
    // upper half, keep the difference and set the quotient bit if it fits.
    assign shifted = {partRem[62:0], 1'b0};
    assign trial   = {1'b0, shifted[63:32]} - {1'b0, divisor};
    assign stepRem = trial[32] ? shifted : {trial[31:0], shifted[31:1], 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= 5'd0;
            partRem      <= 64'd0;
            divisor      <= 32'd0;
            qNeg         <= 1'b0;
            rNeg         <= 1'b0;
            divZero      <= 1'b0;
            resultValid  <= 1'b0;
            quotientReg  <= 32'd0;
            remainderReg <= 32'd0;
        end else if (cancel) begin
            state        <= IDLE;
            count        <= 5'd0;
            resultValid  <= 1'b0;
            quotientReg  <= 32'd0;
            remainderReg <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CALC;
                        count   <= 5'd0;
                        partRem <= {32'd0, applySign(opa, aNeg)};
                        divisor <= applySign(opb, bNeg);
                        qNeg    <= aNeg ^ bNeg;
                        rNeg    <= aNeg;
                        divZero <= (opb == 32'd0);
                    end
                end
                CALC: begin
                    partRem <= stepRem;
                    count   <= count + 5'd1;
                    if (count == 5'd31) begin
                        state        <= DONE;
                        resultValid  <= 1'b1;
                        // Divide-by-zero quotient is all ones regardless of
                        // sign; the remainder path already reproduces opa.
                        quotientReg  <= divZero ? 32'hFFFF_FFFF
                                                : applySign(stepRem[31:0], qNeg);
                        remainderReg <= applySign(stepRem[63:32], rNeg);
                    end
                end
                DONE: begin
                    if (!hold) begin
                        state        <= IDLE;
                        resultValid  <= 1'b0;
                        quotientReg  <= 32'd0;
                        remainderReg <= 32'd0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    resultValid <= 1'b0;
                end
            endcase
        end
    end

    assign stall_req    = ((state == IDLE) && start && !cancel) || ((state == CALC) && !rst);
    assign result_valid = resultValid;
    assign quotient     = quotientReg;
    assign remainder    = remainderReg;

endmodule

// File: tb/tb_exe_divider.sv
module tb_exe_divider;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        cancel = 1'b0;
    logic        hold = 1'b0;
    logic        stall_req;
    logic        result_valid;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    exe_divider dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .signed_div(signed_div),
        .opa(opa),
        .opb(opb),
        .cancel(cancel),
        .hold(hold),
        .stall_req(stall_req),
        .result_valid(result_valid),
        .quotient(quotient),
        .remainder(remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference division semantics, written from the architectural rules.
    function automatic exp_t model(input logic sd, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int sa, sbv;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
        end else if (sd && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.q = 32'h8000_0000;
            e.r = 32'd0;
        end else if (sd) begin
            sa  = a;
            sbv = b;
            e.q = 32'(sa / sbv);
            e.r = 32'(sa % sbv);
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // Issue in the cycle after the next edge (cycle T); returns at T+1 + 1ns.
    task automatic issue(input logic sd, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start      = 1'b1;
        signed_div = sd;
        opa        = a;
        opb        = b;
        sb.push_back(model(sd, a, b));
        @(negedge clk);
        check("stallStart", 32'(stall_req), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns at the negedge of the DONE cycle.
    task automatic waitResult(input string tag);
        int   n;
        exp_t e;
        n = 1;
        @(negedge clk);
        while (!result_valid && n < 40) begin
            check("stallCalc", 32'(stall_req), 32'd1);
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd33);
        check("validDone", 32'(result_valid), 32'd1);
        check("stallDone", 32'(stall_req), 32'd0);
        if (sb.size() == 0) begin
            check("sbEmpty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_q"}, quotient, e.q);
            check({tag, "_r"}, remainder, e.r);
        end
    endtask

    task automatic checkIdle();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idleValid", 32'(result_valid), 32'd0);
        check("idleQ", quotient, 32'd0);
        check("idleR", remainder, 32'd0);
        check("idleStall", 32'(stall_req), 32'd0);
    endtask

    initial begin
        logic [31:0] hq;
        logic [31:0] hr;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rstValid", 32'(result_valid), 32'd0);
        check("rstQ", quotient, 32'd0);
        check("rstR", remainder, 32'd0);
        check("rstStall", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Unsigned 100/7, with a start offered during DONE that must be ignored
        issue(1'b0, 32'd100, 32'd7);
        waitResult("u100d7");
        check("u100d7_qconst", quotient, 32'd14);
        check("u100d7_rconst", remainder, 32'd2);
        start = 1'b1;
        #1;
        check("stallStartInDone", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("noStartFromDone", 32'(stall_req), 32'd0);
        check("noStartFromDoneV", 32'(result_valid), 32'd0);

        // Signed cases
        issue(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
        waitResult("sm7d2");
        check("sm7d2_qconst", quotient, 32'hFFFF_FFFD);
        check("sm7d2_rconst", remainder, 32'hFFFF_FFFF);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        waitResult("sOvf");
        check("sOvf_qconst", quotient, 32'h8000_0000);
        check("sOvf_rconst", remainder, 32'd0);
        issue(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9);
        waitResult("sm100dm7");
        issue(1'b1, 32'd5, 32'hFFFF_FFFD);
        waitResult("s5dm3");

        // Divide by zero
        issue(1'b0, 32'h1234_5678, 32'd0);
        waitResult("uDiv0");
        check("uDiv0_qconst", quotient, 32'hFFFF_FFFF);
        check("uDiv0_rconst", remainder, 32'h1234_5678);
        issue(1'b1, 32'hFFFF_FF00, 32'd0);
        waitResult("sDiv0");
        checkIdle();

        // Start and cancel in the same IDLE cycle
        @(posedge clk);
        #1;
        start  = 1'b1;
        cancel = 1'b1;
        opa    = 32'd9;
        opb    = 32'd3;
        @(negedge clk);
        check("startCancelStall", 32'(stall_req), 32'd0);
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        check("startCancelIdle", 32'(stall_req), 32'd0);
        check("startCancelValid", 32'(result_valid), 32'd0);

        // Cancel at T+10, new start at T+12
        issue(1'b0, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancelStall", 32'(stall_req), 32'd0);
        check("cancelValid", 32'(result_valid), 32'd0);
        void'(sb.pop_front());
        issue(1'b0, 32'd1000, 32'd3);
        waitResult("afterCancel");

        // Hold for 5 cycles from DONE
        issue(1'b0, 32'hDEAD_BEEF, 32'd1234);
        waitResult("holdOp");
        hq   = quotient;
        hr   = remainder;
        hold = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) hold = 1'b0;
            @(negedge clk);
            check("holdValid", 32'(result_valid), 32'd1);
            check("holdQ", quotient, hq);
            check("holdR", remainder, hr);
        end
        checkIdle();

        // Reset at T+20
        issue(1'b1, 32'hFFFF_F000, 32'd17);
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midRstValid", 32'(result_valid), 32'd0);
        check("midRstQ", quotient, 32'd0);
        check("midRstR", remainder, 32'd0);
        check("midRstStall", 32'(stall_req), 32'd0);
        void'(sb.pop_front());
        issue(1'b1, 32'hFFFF_F000, 32'd17);
        waitResult("afterRst");

        // Pseudo-random operands against the model
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            issue(i[0], ra, rb);
            waitResult("rand");
        end

        checkIdle();
        check("sbDrained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
